fta_split128to32: RTL and testbench

FTA_SPLIT128TO32 -- requirements
Module: fta_split128to32

---
 rtl/fta_bus_pkg.sv | 73 +++++++
 rtl/fta_split_beat_ctr.sv | 44 ++++
 rtl/fta_split128to32.sv | 148 ++++++++++++++
 tb/tb_fta_split128to32.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fta_bus_pkg.sv
// rtl/fta_bus_pkg.sv - FTA bus request/response types and beat-split helpers
package fta_bus_pkg;

    typedef enum logic [2:0] {
        SZ_BYT   = 3'd0,
        SZ_WYDE  = 3'd1,
        SZ_TETRA = 3'd2,
        SZ_OCTA  = 3'd3,
        SZ_HEXI  = 3'd4
    } fta_size_t;

    typedef struct packed {
        logic          cyc;
        logic          stb;
        logic          we;
        fta_size_t     sz;
        logic [7:0]    tid;
        logic [31:0]   padr;
        logic [15:0]   sel;
        logic [127:0]  data1;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic          cyc;
        logic          stb;
        logic          we;
        fta_size_t     sz;
        logic [7:0]    tid;
        logic [31:0]   padr;
        logic [3:0]    sel;
        logic [31:0]   data1;
    } fta_cmd_request32_t;

    typedef struct packed {
        logic          ack;
        logic          err;
        logic          rty;
        logic          stall;
        logic [7:0]    tid;
        logic [31:0]   adr;
        logic [127:0]  dat;
    } fta_cmd_response128_t;

    typedef struct packed {
        logic          ack;
        logic          err;
        logic          rty;
        logic          stall;
        logic [7:0]    tid;
        logic [31:0]   adr;
        logic [31:0]   dat;
    } fta_cmd_response32_t;

    localparam int FTA_RETRY_MAX = 3;

    function automatic logic [2:0] fta_beat_count(input fta_size_t sz);
        case (sz)
            SZ_OCTA: return 3'd2;
            SZ_HEXI: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Multi-beat accesses must start on their natural 64/128-bit boundary.
    function automatic logic fta_misaligned(input fta_size_t sz, input logic [31:0] padr);
        case (sz)
            SZ_OCTA: return padr[2];
            SZ_HEXI: return |padr[3:2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fta_split_beat_ctr.sv
// rtl/fta_split_beat_ctr.sv - beat index and per-beat retry counter
module fta_split_beat_ctr #(
    parameter int RETRY_MAX = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       beat_inc_i,
    input  logic       retry_inc_i,
    output logic [1:0] beat_o,
    output logic       retry_exhausted_o
);

    logic [1:0] beat_q, beat_d;
    logic [7:0] retry_q, retry_d;

    always_comb begin
        beat_d  = beat_q;
        retry_d = retry_q;
        if (clr_i) begin
            beat_d  = 2'd0;
            retry_d = 8'd0;
        end else if (beat_inc_i) begin
            beat_d  = beat_q + 2'd1;
            retry_d = 8'd0;
        end else if (retry_inc_i) begin
            retry_d = retry_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q  <= 2'd0;
            retry_q <= 8'd0;
        end else begin
            beat_q  <= beat_d;
            retry_q <= retry_d;
        end
    end

    assign beat_o            = beat_q;
    assign retry_exhausted_o = int'({24'd0, retry_q}) >= RETRY_MAX;

endmodule

// File: rtl/fta_split128to32.sv
// rtl/fta_split128to32.sv - splits one 128-bit FTA request into 32-bit slave beats
module fta_split128to32
    import fta_bus_pkg::*;
#(
    parameter int RETRY_MAX = FTA_RETRY_MAX
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  fta_cmd_request128_t  req128_i,
    output fta_cmd_response128_t resp128_o,
    output fta_cmd_request32_t   req32_o,
    input  fta_cmd_response32_t  resp32_i,
    output logic                 busy_o
);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    state_t              state_q, state_d;
    fta_cmd_request128_t req_q, req_d;
    logic [127:0]        gather_q, gather_d;
    logic                err_q, err_d;

    logic [1:0] lane, beat, word;
    logic [2:0] nbeats;
    logic       last_beat, misaligned, tid_match, retry_exhausted;
    logic       ctr_clr, beat_inc, retry_inc;
    logic       unused_bits;

    assign lane       = req_q.padr[3:2];
    assign word       = lane + beat;
    assign nbeats     = fta_beat_count(req_q.sz);
    assign last_beat  = ({1'b0, beat} + 3'd1) == nbeats;
    assign misaligned = fta_misaligned(req_q.sz, req_q.padr);
    assign tid_match  = resp32_i.tid == req_q.tid;
    assign unused_bits = ^{resp32_i.adr, req_q.cyc, req_q.stb};

    fta_split_beat_ctr #(.RETRY_MAX(RETRY_MAX)) u_ctr (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .clr_i             (ctr_clr),
        .beat_inc_i        (beat_inc),
        .retry_inc_i       (retry_inc),
        .beat_o            (beat),
        .retry_exhausted_o (retry_exhausted)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        gather_d  = gather_q;
        err_d     = err_q;
        ctr_clr   = 1'b0;
        beat_inc  = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req128_i.cyc && req128_i.stb) begin
                    req_d    = req128_i;
                    gather_d = '0;
                    err_d    = 1'b0;
                    ctr_clr  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (misaligned) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (!resp32_i.stall) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // err outranks ack, and a matching ack outranks rty
                if (resp32_i.err) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (resp32_i.ack && tid_match) begin
                    gather_d[{word, 5'd0} +: 32] = resp32_i.dat;
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_inc = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end else if (resp32_i.rty) begin
                    if (retry_exhausted) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        retry_inc = 1'b1;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            gather_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            gather_q <= gather_d;
            err_q    <= err_d;
        end
    end

    assign busy_o = state_q != ST_IDLE;

    always_comb begin
        req32_o   = '0;
        resp128_o = '0;
        if ((state_q == ST_WAIT) || ((state_q == ST_ISSUE) && !misaligned)) begin
            req32_o.cyc   = 1'b1;
            req32_o.stb   = state_q == ST_ISSUE;
            req32_o.we    = req_q.we;
            req32_o.sz    = req_q.sz;
            req32_o.tid   = req_q.tid;
            req32_o.padr  = {req_q.padr[31:4], word, 2'b00};
            req32_o.sel   = (nbeats == 3'd1) ? req_q.sel[{word, 2'd0} +: 4] : 4'hF;
            req32_o.data1 = req_q.data1[{word, 5'd0} +: 32];
        end
        if (state_q == ST_RESP) begin
            resp128_o.ack = !err_q;
            resp128_o.err = err_q;
            resp128_o.tid = req_q.tid;
            resp128_o.adr = req_q.padr;
            if (req_q.we)
                resp128_o.dat = '0;
            else if (nbeats == 3'd1)
                resp128_o.dat = {4{gather_q[{lane, 5'd0} +: 32]}};
            else
                resp128_o.dat = gather_q;
        end
        resp128_o.stall = busy_o;
    end

endmodule

// File: tb/tb_fta_split128to32.sv
// tb/tb_fta_split128to32.sv - directed self-checking bench for fta_split128to32
module tb_fta_split128to32;
    import fta_bus_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    fta_cmd_request128_t  req128_i;
    fta_cmd_response128_t resp128_o;
    fta_cmd_request32_t   req32_o;
    fta_cmd_response32_t  resp32_i;
    logic                 busy_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] cur_tid;

    fta_split128to32 #(.RETRY_MAX(3)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req128_i  (req128_i),
        .resp128_o (resp128_o),
        .req32_o   (req32_o),
        .resp32_i  (resp32_i),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic fta_cmd_request128_t mk_req(input logic we, input fta_size_t sz,
            input logic [7:0] tid, input logic [31:0] padr, input logic [15:0] sel,
            input logic [127:0] data);
        fta_cmd_request128_t r;
        r       = '0;
        r.cyc   = 1'b1;
        r.stb   = 1'b1;
        r.we    = we;
        r.sz    = sz;
        r.tid   = tid;
        r.padr  = padr;
        r.sel   = sel;
        r.data1 = data;
        return r;
    endfunction

    task automatic send(input fta_cmd_request128_t r);
        req128_i = r;
        cur_tid  = r.tid;
        step();
        req128_i = '0;
    endtask

    // Expects ISSUE now; acks the beat on the WAIT cycle with the latched tid.
    task automatic do_beat(input logic [31:0] ep, input logic [3:0] es, input logic [31:0] ed,
            input logic [31:0] rd);
        check("issue_cyc_stb", {req32_o.cyc, req32_o.stb}, 2'b11);
        check("issue_padr", req32_o.padr, ep);
        check("issue_sel", req32_o.sel, es);
        check("issue_dat", req32_o.data1, ed);
        check("issue_tid", req32_o.tid, cur_tid);
        step();
        check("wait_cyc_stb", {req32_o.cyc, req32_o.stb}, 2'b10);
        resp32_i     = '0;
        resp32_i.ack = 1'b1;
        resp32_i.tid = cur_tid;
        resp32_i.dat = rd;
        step();
        resp32_i = '0;
    endtask

    task automatic expect_resp(input logic ea, input logic ee, input logic [31:0] eadr,
            input logic [127:0] edat);
        check("resp_ack", resp128_o.ack, ea);
        check("resp_err", resp128_o.err, ee);
        check("resp_tid", resp128_o.tid, cur_tid);
        check("resp_adr", resp128_o.adr, eadr);
        check("resp_dat", resp128_o.dat, edat);
        check("resp_no_cyc", req32_o.cyc, 1'b0);
        step();
        check("resp_one_cycle", {resp128_o.ack, resp128_o.err}, 2'b00);
        check("resp_idle_busy", busy_o, 1'b0);
    endtask

    initial begin
        rst_i    = 1'b1;
        resp32_i = '0;
        cur_tid  = 8'h00;
        req128_i = mk_req(1'b0, SZ_TETRA, 8'h01, 32'h0000_0000, 16'hFFFF, '0);
        step();
        step();
        check("rst_busy", busy_o, 1'b0);
        check("rst_req32", req32_o, '0);
        check("rst_resp128_zero", resp128_o == '0, 1'b1);
        req128_i = '0;
        rst_i    = 1'b0;
        step();
        check("idle_busy", busy_o, 1'b0);

        // hexi read with a stall, an ignored second request and a wrong-tid ack
        send(mk_req(1'b0, SZ_HEXI, 8'h05, 32'h0000_1000, 16'hFFFF, '0));
        check("hexi_busy", busy_o, 1'b1);
        check("hexi_stall", resp128_o.stall, 1'b1);
        resp32_i.stall = 1'b1;
        req128_i = mk_req(1'b1, SZ_TETRA, 8'h09, 32'h0000_5000, 16'hFFFF, '0);
        step();
        resp32_i = '0;
        do_beat(32'h0000_1000, 4'hF, 32'h0, 32'h11);
        req128_i = '0;
        check("hexi_b1_cyc_stb", {req32_o.cyc, req32_o.stb}, 2'b11);
        check("hexi_b1_padr", req32_o.padr, 32'h0000_1004);
        step();
        resp32_i.ack = 1'b1;
        resp32_i.tid = 8'h06;
        resp32_i.dat = 32'hFF;
        step();
        check("hexi_badtid_wait", {req32_o.cyc, req32_o.stb}, 2'b10);
        resp32_i.tid = 8'h05;
        resp32_i.dat = 32'h22;
        step();
        resp32_i = '0;
        do_beat(32'h0000_1008, 4'hF, 32'h0, 32'h33);
        do_beat(32'h0000_100C, 4'hF, 32'h0, 32'h44);
        expect_resp(1'b1, 1'b0, 32'h0000_1000, {32'h44, 32'h33, 32'h22, 32'h11});

        // octa write at upper half
        send(mk_req(1'b1, SZ_OCTA, 8'h07, 32'h0000_2008, 16'hFFFF,
                    {64'hAABBCCDD_11223344, 64'h0}));
        check("octa_we", req32_o.we, 1'b1);
        do_beat(32'h0000_2008, 4'hF, 32'h1122_3344, 32'hDEAD);
        do_beat(32'h0000_200C, 4'hF, 32'hAABB_CCDD, 32'hBEEF);
        expect_resp(1'b1, 1'b0, 32'h0000_2008, '0);

        // misaligned octa: no beat, err two cycles after request
        send(mk_req(1'b0, SZ_OCTA, 8'h08, 32'h0000_2004, 16'hFFFF, '0));
        check("misal_no_cyc", req32_o.cyc, 1'b0);
        check("misal_no_resp_yet", {resp128_o.ack, resp128_o.err}, 2'b00);
        step();
        expect_resp(1'b0, 1'b1, 32'h0000_2004, '0);

        // byte read in lane 2
        send(mk_req(1'b0, SZ_BYT, 8'h0A, 32'h0000_3009, 16'h0200,
                    {32'h4, 32'h3, 32'h2, 32'h1}));
        do_beat(32'h0000_3008, 4'h2, 32'h3, 32'h0000_AB00);
        expect_resp(1'b1, 1'b0, 32'h0000_3009, {4{32'h0000_AB00}});

        // tetra read: four rty exhaust the retries
        send(mk_req(1'b0, SZ_TETRA, 8'h0B, 32'h0000_4004, 16'h00F0, '0));
        for (int i = 0; i < 4; i++) begin
            check("rty_issue", {req32_o.cyc, req32_o.stb}, 2'b11);
            check("rty_issue_padr", req32_o.padr, 32'h0000_4004);
            step();
            resp32_i     = '0;
            resp32_i.rty = 1'b1;
            step();
            resp32_i = '0;
        end
        expect_resp(1'b0, 1'b1, 32'h0000_4004, '0);

        // two rty, then ack together with rty: ack wins
        send(mk_req(1'b0, SZ_TETRA, 8'h0C, 32'h0000_4004, 16'h00F0, '0));
        for (int i = 0; i < 2; i++) begin
            check("rty2_issue", {req32_o.cyc, req32_o.stb}, 2'b11);
            step();
            resp32_i     = '0;
            resp32_i.rty = 1'b1;
            step();
            resp32_i = '0;
        end
        check("rty2_third_issue", {req32_o.cyc, req32_o.stb}, 2'b11);
        check("rty2_sel", req32_o.sel, 4'hF);
        step();
        resp32_i.ack = 1'b1;
        resp32_i.rty = 1'b1;
        resp32_i.tid = 8'h0C;
        resp32_i.dat = 32'h0000_5A5A;
        step();
        resp32_i = '0;
        expect_resp(1'b1, 1'b0, 32'h0000_4004, {4{32'h0000_5A5A}});

        // ack and err in the same cycle: err wins
        send(mk_req(1'b0, SZ_TETRA, 8'h0D, 32'h0000_6000, 16'h000F, '0));
        step();
        resp32_i.ack = 1'b1;
        resp32_i.err = 1'b1;
        resp32_i.tid = 8'h0D;
        resp32_i.dat = 32'h1234_5678;
        step();
        resp32_i = '0;
        expect_resp(1'b0, 1'b1, 32'h0000_6000, '0);

        // reset while waiting on beat 2 of a hexi read
        send(mk_req(1'b0, SZ_HEXI, 8'h0E, 32'h0000_7000, 16'hFFFF, '0));
        do_beat(32'h0000_7000, 4'hF, 32'h0, 32'h1);
        check("rst_mid_b1_padr", req32_o.padr, 32'h0000_7004);
        step();
        check("rst_mid_wait", {req32_o.cyc, req32_o.stb}, 2'b10);
        rst_i = 1'b1;
        #1;
        check("rst_mid_req32", req32_o, '0);
        check("rst_mid_busy", busy_o, 1'b0);
        step();
        check("rst_mid_resp_zero", resp128_o == '0, 1'b1);
        rst_i = 1'b0;
        step();
        check("rst_mid_no_resp", {resp128_o.ack, resp128_o.err}, 2'b00);
        check("rst_mid_no_cyc", req32_o.cyc, 1'b0);

        // normal transfer after reset
        send(mk_req(1'b1, SZ_TETRA, 8'h0F, 32'h0000_8000, 16'h000F,
                    {96'h0, 32'hCAFE_F00D}));
        do_beat(32'h0000_8000, 4'hF, 32'hCAFE_F00D, 32'h0);
        expect_resp(1'b1, 1'b0, 32'h0000_8000, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
